// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with one write port and two combinational read
// ports, asynchronous reset-to-zero, optional write-to-read bypass and a
// clear sequencer that zeroes one register per cycle while busy is high.
module regfile_2r1w #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_REGS = 8,
    parameter int unsigned ADDR_W = 3,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              write,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    input  logic              clear_req,
    output logic              busy,
    output logic              write_drop
);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    // Index of the last register; the sweep returns to IDLE once it is zeroed.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              write_drop_q, write_drop_d;
    logic [DATA_W-1:0] regs_q [N_REGS];
    logic [DATA_W-1:0] regs_d [N_REGS];

    logic              sweeping;
    logic              wr_in_range;
    logic              wr_accept;

    assign sweeping   = (state_q == SWEEP);
    assign busy       = sweeping;
    assign write_drop = write_drop_q;

    // Qualify the write request: idle sequencer and an address that exists.
    always_comb begin
        wr_in_range = 1'b0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (writenum == ADDR_W'(i)) begin
                wr_in_range = 1'b1;
            end
        end
        wr_accept = write && !sweeping && wr_in_range;
    end

    // Next-state for the clear sequencer and the refused-write pulse.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        write_drop_d = write && sweeping;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                if (ptr_q == LAST_IDX) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Next contents of the storage array: accepted write or sweep zeroing.
    always_comb begin
        for (int unsigned i = 0; i < N_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_accept && (writenum == ADDR_W'(i))) begin
                regs_d[i] = data_in;
            end
            if (sweeping && (ptr_q == ADDR_W'(i))) begin
                regs_d[i] = '0;
            end
        end
    end

    // Port A read mux; unmapped addresses read zero, bypass overrides storage.
    always_comb begin
        data_out_a = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (readnum_a == ADDR_W'(i)) begin
                data_out_a = regs_q[i];
            end
        end
        if (BYPASS && wr_accept && (writenum == readnum_a)) begin
            data_out_a = data_in;
        end
    end

    // Port B read mux; identical to port A.
    always_comb begin
        data_out_b = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (readnum_b == ADDR_W'(i)) begin
                data_out_b = regs_q[i];
            end
        end
        if (BYPASS && wr_accept && (writenum == readnum_b)) begin
            data_out_b = data_in;
        end
    end

    // State, pointer, pulse and storage flops; reset aborts any sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            write_drop_q <= 1'b0;
            for (int unsigned i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            write_drop_q <= write_drop_d;
            for (int unsigned i = 0; i < N_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: drives an 8-register bypassing instance and a 6-register
// non-bypassing instance with shared stimulus, checking both against a
// behavioural model of the register file.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] data_in = '0;
    logic [2:0]  writenum = '0;
    logic        write = 1'b0;
    logic [2:0]  readnum_a = '0;
    logic [2:0]  readnum_b = '0;
    logic        clear_req = 1'b0;

    logic [15:0] a8, b8, a6, b6;
    logic        busy8, drop8, busy6, drop6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_W(16), .N_REGS(8), .ADDR_W(3), .BYPASS(1)) u_dut8 (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
        .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(a8), .data_out_b(b8), .clear_req(clear_req),
        .busy(busy8), .write_drop(drop8)
    );

    regfile_2r1w #(.DATA_W(16), .N_REGS(6), .ADDR_W(3), .BYPASS(0)) u_dut6 (
        .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
        .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(a6), .data_out_b(b6), .clear_req(clear_req),
        .busy(busy6), .write_drop(drop6)
    );

    // Reference model: index 0 = 8-register bypass build, 1 = 6-register build.
    logic [15:0] mem [2][8];
    int          nregs [2] = '{8, 6};
    bit          byp   [2] = '{1'b1, 1'b0};
    int          sweep_pos [2];   // next register to zero, -1 when not sweeping
    bit          mdrop [2];

    function automatic bit m_accept(int k);
        return write && (sweep_pos[k] < 0) && (int'(writenum) < nregs[k]);
    endfunction

    function automatic logic [15:0] m_read(int k, logic [2:0] addr);
        if (byp[k] && m_accept(k) && (writenum == addr)) return data_in;
        if (int'(addr) >= nregs[k]) return 16'h0000;
        return mem[k][addr];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 8; r++) mem[k][r] = '0;
            sweep_pos[k] = -1;
            mdrop[k] = 1'b0;
        end
    endtask

    task automatic m_edge();
        for (int k = 0; k < 2; k++) begin
            if (sweep_pos[k] >= 0) begin
                mdrop[k] = write;
                mem[k][sweep_pos[k]] = '0;
                sweep_pos[k]++;
                if (sweep_pos[k] == nregs[k]) sweep_pos[k] = -1;
            end else begin
                mdrop[k] = 1'b0;
                if (m_accept(k)) mem[k][writenum] = data_in;
                if (clear_req) sweep_pos[k] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " a8"},    a8,           m_read(0, readnum_a));
        chk({tag, " b8"},    b8,           m_read(0, readnum_b));
        chk({tag, " busy8"}, 16'(busy8),   16'(sweep_pos[0] >= 0));
        chk({tag, " drop8"}, 16'(drop8),   16'(mdrop[0]));
        chk({tag, " a6"},    a6,           m_read(1, readnum_a));
        chk({tag, " b6"},    b6,           m_read(1, readnum_b));
        chk({tag, " busy6"}, 16'(busy6),   16'(sweep_pos[1] >= 0));
        chk({tag, " drop6"}, 16'(drop6),   16'(mdrop[1]));
    endtask

    // One clock: apply inputs after the falling edge, check, then take the edge.
    task automatic step(input logic w, input logic [2:0] wn, input logic [15:0] d,
                        input logic [2:0] ra, input logic [2:0] rb, input logic clr);
        write = w; writenum = wn; data_in = d;
        readnum_a = ra; readnum_b = rb; clear_req = clr;
        #1;
        check_all("step");
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    // Idle inputs with chosen read addresses, settled for explicit checks.
    task automatic look(input logic [2:0] ra, input logic [2:0] rb);
        write = 1'b0; clear_req = 1'b0; readnum_a = ra; readnum_b = rb;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_reset();
        check_all("reset");
        reset = 1'b0;
    endtask

    int cnt8, cnt6;

    initial begin
        m_reset();
        @(negedge clk);
        readnum_a = 3'd0; readnum_b = 3'd7;
        do_reset();
        chk("rst a8", a8, 16'h0000);
        chk("rst busy8", 16'(busy8), 16'h0000);

        // Two writes, then dual reads including the same register on both ports.
        step(1'b1, 3'd3, 16'h1234, 3'd0, 3'd0, 1'b0);
        step(1'b1, 3'd5, 16'hBEEF, 3'd0, 3'd0, 1'b0);
        look(3'd3, 3'd5);
        chk("rd r3 a8", a8, 16'h1234);
        chk("rd r5 b8", b8, 16'hBEEF);
        chk("rd r3 a6", a6, 16'h1234);
        look(3'd5, 3'd5);
        chk("same a8", a8, 16'hBEEF);
        chk("same b8", b8, 16'hBEEF);

        // Bypass versus stored value in the same cycle.
        step(1'b1, 3'd2, 16'h0001, 3'd0, 3'd0, 1'b0);
        write = 1'b1; writenum = 3'd2; data_in = 16'hA5A5; readnum_a = 3'd2;
        #1;
        chk("byp a8", a8, 16'hA5A5);
        chk("nobyp a6", a6, 16'h0001);
        step(1'b1, 3'd2, 16'hA5A5, 3'd2, 3'd0, 1'b0);
        look(3'd2, 3'd0);
        chk("nobyp next a6", a6, 16'hA5A5);

        // Fill, clear, and count busy cycles on both builds.
        for (int i = 0; i < 8; i++)
            step(1'b1, 3'(i), 16'(i * 16'h1111 + 1), 3'd0, 3'd7, 1'b0);
        step(1'b0, 3'd0, 16'h0, 3'd0, 3'd7, 1'b1);
        cnt8 = 1; cnt6 = 1;
        step(1'b0, 3'd0, 16'h0, 3'd0, 3'd7, 1'b0);
        look(3'd0, 3'd7);
        chk("sweep r0 a8", a8, 16'h0000);
        chk("sweep r7 b8", b8, 16'h7778);
        for (int i = 0; i < 12; i++) begin
            look(3'(i % 8), 3'd7);
            if (busy8) cnt8++;
            if (busy6) cnt6++;
            step(1'b0, 3'd0, 16'h0, 3'(i % 8), 3'd7, 1'b0);
        end
        chk("busy len 8", 16'(cnt8), 16'd8);
        chk("busy len 6", 16'(cnt6), 16'd6);
        for (int r = 0; r < 8; r++) begin
            look(3'(r), 3'(r));
            chk($sformatf("cleared r%0d", r), a8, 16'h0000);
        end

        // Write during a sweep is refused and pulses write_drop.
        step(1'b1, 3'd6, 16'h1357, 3'd6, 3'd6, 1'b0);
        step(1'b0, 3'd0, 16'h0, 3'd6, 3'd6, 1'b1);
        step(1'b1, 3'd6, 16'h7777, 3'd6, 3'd6, 1'b0);
        look(3'd6, 3'd6);
        chk("drop8 pulse", 16'(drop8), 16'h0001);
        for (int i = 0; i < 9; i++) step(1'b0, 3'd0, 16'h0, 3'd6, 3'd0, 1'b0);
        look(3'd6, 3'd6);
        chk("r6 after sweep", a8, 16'h0000);
        chk("drop8 gone", 16'(drop8), 16'h0000);
        step(1'b1, 3'd6, 16'h7777, 3'd6, 3'd6, 1'b0);
        look(3'd6, 3'd6);
        chk("r6 accepted", a8, 16'h7777);
        chk("no drop8", 16'(drop8), 16'h0000);
        chk("r6 oob on 6", a6, 16'h0000);

        // Out-of-range write on the 6-register build.
        step(1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd7, 1'b0);
        look(3'd7, 3'd7);
        chk("oob rd a6", a6, 16'h0000);
        chk("oob no drop6", 16'(drop6), 16'h0000);
        chk("r7 a8", a8, 16'hFFFF);

        // Reset in the middle of a sweep.
        step(1'b1, 3'd7, 16'h5555, 3'd7, 3'd1, 1'b0);
        step(1'b0, 3'd0, 16'h0, 3'd7, 3'd1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 16'h0, 3'd7, 3'd1, 1'b0);
        look(3'd7, 3'd1);
        chk("pre-rst r7", a8, 16'h5555);
        chk("pre-rst busy", 16'(busy8), 16'h0001);
        do_reset();
        chk("mid-rst busy8", 16'(busy8), 16'h0000);
        chk("mid-rst r7", a8, 16'h0000);
        step(1'b1, 3'd1, 16'h4242, 3'd7, 3'd1, 1'b0);
        look(3'd1, 3'd1);
        chk("post-rst r1", a8, 16'h4242);
        chk("post-rst r1 a6", a6, 16'h4242);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 24) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
